// File: rtl/evt_pkg.sv
// ----------------------------------------------------------------------------
// evt_pkg
// Shared constants and types for the event counter array.
//   N_CH_DEF     default number of event channels
//   CNT_W_DEF    default per-channel counter width
//   count_mode_e behaviour of a counter when a hit arrives at its maximum
// ----------------------------------------------------------------------------
package evt_pkg;

    localparam int N_CH_DEF  = 3;
    localparam int CNT_W_DEF = 8;

    typedef enum logic {
        COUNT_WRAP = 1'b0,  // roll over to zero
        COUNT_SAT  = 1'b1   // stick at all-ones
    } count_mode_e;

endpackage : evt_pkg

// File: rtl/evt_chan.sv
// ----------------------------------------------------------------------------
// evt_chan
// One event channel: previous-sample register, hit detection, counter and
// sticky overflow flag.
//   clk_i   clock, rising edge
//   rst_i   asynchronous active-high reset
//   en_i    count enable (hits are ignored while low)
//   clr_i   synchronous clear of counter and overflow; beats a same-cycle hit
//   evt_i   event input, synchronous to clk_i
//   cnt_o   registered count
//   ovf_o   sticky overflow flag
// ----------------------------------------------------------------------------
module evt_chan
    import evt_pkg::*;
#(
    parameter int          CNT_W = CNT_W_DEF,
    parameter count_mode_e MODE  = COUNT_WRAP,
    parameter bit          EDGE  = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             evt_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             evt_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             hit;

    // evt_q follows the input every cycle, independent of enable and clear,
    // so re-enabling never produces a stale edge.
    assign hit = EDGE ? (evt_i & ~evt_q) : evt_i;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (en_i && hit) begin
            if (cnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
                cnt_d = (MODE == COUNT_SAT) ? CNT_MAX : '0;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            evt_q <= 1'b0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            evt_q <= evt_i;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule : evt_chan

// File: rtl/evt_counter_array.sv
// ----------------------------------------------------------------------------
// evt_counter_array
// N_CH independent event counters with a common enable/clear and an
// all-channel snapshot register.
//   i_clk       clock, rising edge
//   i_rst       asynchronous active-high reset
//   i_en        global count enable
//   i_clr       synchronous clear of all counters and overflow flags
//   i_evt       per-channel event inputs
//   i_snap      snapshot request
//   o_cnt       live count per channel (index = channel)
//   o_ovf       sticky overflow flag per channel
//   o_snap_cnt  counts captured by the last snapshot
//   o_snap_vld  one-cycle pulse marking a new snapshot
// ----------------------------------------------------------------------------
module evt_counter_array
    import evt_pkg::*;
#(
    parameter int N_CH     = N_CH_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int SATURATE = 0,
    parameter int EDGE     = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_en,
    input  logic                       i_clr,
    input  logic [N_CH-1:0]            i_evt,
    input  logic                       i_snap,
    output logic [N_CH-1:0][CNT_W-1:0] o_cnt,
    output logic [N_CH-1:0]            o_ovf,
    output logic [N_CH-1:0][CNT_W-1:0] o_snap_cnt,
    output logic                       o_snap_vld
);

    localparam count_mode_e MODE     = (SATURATE != 0) ? COUNT_SAT : COUNT_WRAP;
    localparam bit          EDGE_BIT = (EDGE != 0);

    logic [N_CH-1:0][CNT_W-1:0] cnt;
    logic [N_CH-1:0]            ovf;

    logic [N_CH-1:0][CNT_W-1:0] snap_cnt_q, snap_cnt_d;
    logic                       snap_vld_q, snap_vld_d;

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        evt_chan #(
            .CNT_W (CNT_W),
            .MODE  (MODE),
            .EDGE  (EDGE_BIT)
        ) u_chan (
            .clk_i (i_clk),
            .rst_i (i_rst),
            .en_i  (i_en),
            .clr_i (i_clr),
            .evt_i (i_evt[g]),
            .cnt_o (cnt[g]),
            .ovf_o (ovf[g])
        );
    end

    // The snapshot samples the registered counts, i.e. the values before
    // this edge's update; a same-cycle clear therefore still captures the
    // pre-clear counts.
    always_comb begin
        snap_cnt_d = snap_cnt_q;
        snap_vld_d = i_snap;
        if (i_snap) begin
            snap_cnt_d = cnt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            snap_cnt_q <= '0;
            snap_vld_q <= 1'b0;
        end else begin
            snap_cnt_q <= snap_cnt_d;
            snap_vld_q <= snap_vld_d;
        end
    end

    assign o_cnt      = cnt;
    assign o_ovf      = ovf;
    assign o_snap_cnt = snap_cnt_q;
    assign o_snap_vld = snap_vld_q;

endmodule : evt_counter_array

// File: tb/tb_evt_counter_array.sv
// ----------------------------------------------------------------------------
// tb_evt_counter_array
// Directed bench. Three instances share one set of inputs:
//   dut      defaults (wrap, rising-edge counting)
//   dut_lvl  level counting (EDGE=0)
//   dut_sat  saturating counters (SATURATE=1)
// Inputs change 1 ns after a rising edge; outputs are sampled at the same
// point, so each step shows the effect of exactly one edge.
// ----------------------------------------------------------------------------
module tb_evt_counter_array;

    localparam int N_CH  = 3;
    localparam int CNT_W = 8;

    logic                       clk;
    logic                       rst;
    logic                       en;
    logic                       clr;
    logic [N_CH-1:0]            evt;
    logic                       snap;

    logic [N_CH-1:0][CNT_W-1:0] cnt,      cnt_lvl,      cnt_sat;
    logic [N_CH-1:0]            ovf,      ovf_lvl,      ovf_sat;
    logic [N_CH-1:0][CNT_W-1:0] snap_cnt, snap_cnt_lvl, snap_cnt_sat;
    logic                       snap_vld, snap_vld_lvl, snap_vld_sat;

    int checks   = 0;
    int failures = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    evt_counter_array #(.N_CH(N_CH), .CNT_W(CNT_W), .SATURATE(0), .EDGE(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .i_evt(evt), .i_snap(snap),
        .o_cnt(cnt), .o_ovf(ovf), .o_snap_cnt(snap_cnt), .o_snap_vld(snap_vld)
    );

    evt_counter_array #(.N_CH(N_CH), .CNT_W(CNT_W), .SATURATE(0), .EDGE(0)) dut_lvl (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .i_evt(evt), .i_snap(snap),
        .o_cnt(cnt_lvl), .o_ovf(ovf_lvl), .o_snap_cnt(snap_cnt_lvl), .o_snap_vld(snap_vld_lvl)
    );

    evt_counter_array #(.N_CH(N_CH), .CNT_W(CNT_W), .SATURATE(1), .EDGE(1)) dut_sat (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .i_evt(evt), .i_snap(snap),
        .o_cnt(cnt_sat), .o_ovf(ovf_sat), .o_snap_cnt(snap_cnt_sat), .o_snap_vld(snap_vld_sat)
    );

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [N_CH-1:0] mask);
        evt = mask;
        step();
        evt = '0;
        step();
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        clr  = 1'b0;
        evt  = '0;
        snap = 1'b0;

        // Reset state, before any clock edge.
        #2;
        check("rst_cnt",      32'(cnt),      32'd0);
        check("rst_ovf",      32'(ovf),      32'd0);
        check("rst_snap_cnt", 32'(snap_cnt), 32'd0);
        check("rst_snap_vld", 32'(snap_vld), 32'd0);
        step();
        step();
        rst = 1'b0;
        en  = 1'b1;
        step();

        // Single pulse on channel 0: visible one edge later, others untouched.
        evt = 3'b001;
        check("pulse_pre_cnt0", 32'(cnt[0]), 32'd0);
        step();
        evt = '0;
        check("pulse_cnt0", 32'(cnt[0]), 32'd1);
        check("pulse_cnt1", 32'(cnt[1]), 32'd0);
        check("pulse_cnt2", 32'(cnt[2]), 32'd0);
        step();

        // Channel 1 held high for 10 cycles: one edge vs ten levels.
        evt = 3'b010;
        for (int i = 0; i < 10; i++) step();
        evt = '0;
        step();
        check("hold_edge_cnt1",  32'(cnt[1]),     32'd1);
        check("hold_level_cnt1", 32'(cnt_lvl[1]), 32'd10);

        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_cnt", 32'(cnt), 32'd0);
        check("clr_cnt_sat", 32'(cnt_sat), 32'd0);

        // 256 pulses on channel 2: wrap vs saturate, overflow sticky.
        for (int i = 0; i < 255; i++) pulse(3'b100);
        check("wrap_cnt2_255", 32'(cnt[2]), 32'd255);
        check("wrap_ovf2_pre", 32'(ovf[2]), 32'd0);
        pulse(3'b100);
        check("wrap_cnt2",  32'(cnt[2]),     32'd0);
        check("wrap_ovf2",  32'(ovf[2]),     32'd1);
        check("sat_cnt2",   32'(cnt_sat[2]), 32'd255);
        check("sat_ovf2",   32'(ovf_sat[2]), 32'd1);
        check("ovf_others", 32'(ovf[1:0]),   32'd0);
        pulse(3'b100);
        check("wrap_cnt2_after", 32'(cnt[2]),     32'd1);
        check("wrap_ovf2_stick", 32'(ovf[2]),     32'd1);
        check("sat_cnt2_after",  32'(cnt_sat[2]), 32'd255);

        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_ovf", 32'(ovf), 32'd0);

        // Counts 5/7/9 with simultaneous hits, then snapshot + clear together.
        for (int i = 0; i < 9; i++) pulse({(i < 9), (i < 7), (i < 5)});
        check("cnt0_5", 32'(cnt[0]), 32'd5);
        check("cnt1_7", 32'(cnt[1]), 32'd7);
        check("cnt2_9", 32'(cnt[2]), 32'd9);
        snap = 1'b1;
        clr  = 1'b1;
        step();
        snap = 1'b0;
        clr  = 1'b0;
        check("snapclr_snap0", 32'(snap_cnt[0]), 32'd5);
        check("snapclr_snap1", 32'(snap_cnt[1]), 32'd7);
        check("snapclr_snap2", 32'(snap_cnt[2]), 32'd9);
        check("snapclr_vld",   32'(snap_vld),    32'd1);
        check("snapclr_cnt",   32'(cnt),         32'd0);
        step();
        check("snap_vld_drop", 32'(snap_vld),    32'd0);
        check("snap_hold2",    32'(snap_cnt[2]), 32'd9);

        // Back-to-back snapshots, the first coinciding with a hit.
        pulse(3'b001);
        pulse(3'b001);
        snap = 1'b1;
        evt  = 3'b001;
        step();
        evt  = '0;
        check("snap1_cnt0", 32'(snap_cnt[0]), 32'd2);
        check("snap1_vld",  32'(snap_vld),    32'd1);
        check("snap1_live", 32'(cnt[0]),      32'd3);
        step();
        snap = 1'b0;
        check("snap2_cnt0", 32'(snap_cnt[0]), 32'd3);
        check("snap2_vld",  32'(snap_vld),    32'd1);
        step();
        check("snap3_vld",  32'(snap_vld),    32'd0);

        // Disabled: four pulses everywhere change nothing.
        en = 1'b0;
        for (int i = 0; i < 4; i++) pulse(3'b111);
        check("dis_cnt0", 32'(cnt[0]), 32'd3);
        check("dis_cnt1", 32'(cnt[1]), 32'd0);
        check("dis_cnt2", 32'(cnt[2]), 32'd0);
        // Edge register keeps tracking while disabled: a level that rose
        // during disable is not an edge once enabled.
        evt = 3'b010;
        step();
        en = 1'b1;
        step();
        evt = '0;
        step();
        check("dis_track_cnt1", 32'(cnt[1]), 32'd0);

        // Hit coincident with clear is lost.
        evt = 3'b001;
        clr = 1'b1;
        step();
        evt = '0;
        clr = 1'b0;
        check("clr_beats_hit", 32'(cnt[0]), 32'd0);
        step();

        // Event held high across reset release counts once.
        evt = 3'b100;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check("rst_edge_cnt2", 32'(cnt[2]), 32'd1);
        step();
        check("rst_edge_hold", 32'(cnt[2]), 32'd1);
        evt = '0;
        step();

        // Asynchronous reset mid-stream, with a nonzero snapshot present.
        pulse(3'b001);
        pulse(3'b001);
        pulse(3'b001);
        snap = 1'b1;
        step();
        snap = 1'b0;
        check("pre_rst_cnt0",  32'(cnt[0]),      32'd3);
        check("pre_rst_snap0", 32'(snap_cnt[0]), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_cnt",      32'(cnt),      32'd0);
        check("async_rst_ovf",      32'(ovf),      32'd0);
        check("async_rst_snap_cnt", 32'(snap_cnt), 32'd0);
        check("async_rst_snap_vld", 32'(snap_vld), 32'd0);
        step();
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_evt_counter_array
